flash_master: RTL and testbench
===============================

Name: flash_master

Overview:
SPI flash read initiator (SPI mode 0). It is the master end of the flash bus that sim_flash_slave answers in simulation, and it drives the physical flash in hardware. The memory space issues a word-burst read request. The block sends READ (0x03) plus a 24-bit address, then streams little-endian 32-bit words back, one pulse per word. It instantiates inside risc_p and drives the flash_* pins.

Parameters:
CLK_DIV, 1, clk cycles per SCK half-period (>=1); SPI bit time = 2*CLK_DIV clk cycles
CS_HIGH_CYCLES, 2, minimum clk cycles flash_csn held high between transactions (>=1)

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
cmd_valid_i  input  1  read request valid
cmd_ready_o  output  1  block can accept a request
addr_i  input  24  flash byte address (sampled at handshake)
len_i  input  8  burst length minus one; words = len_i+1 (1..256)
abort_i  input  1  terminate current burst
data_o  output  32  received word; first byte received = data_o[7:0]
data_valid_o  output  1  one-cycle pulse per received word
busy_o  output  1  transaction in progress (csn low or deselect hold)
flash_csn  output  1  chip select, active-low
flash_clk  output  1  SCK
flash_mosi  output  1  serial out, MSB first
flash_miso  input  1  serial in
flash_wpn  output  1  write protect, constant 1
flash_holdn  output  1  hold, constant 1

Behaviour:
- Reset values: cmd_ready_o=1, busy_o=0, data_valid_o=0, data_o=0, flash_csn=1, flash_clk=0, flash_mosi=0; flash_wpn=flash_holdn=1 always.
- Handshake: cmd_valid_i&cmd_ready_o at a clk edge accepts the request (E0). addr_i and len_i are latched there. cmd_ready_o drops at E0 and stays 0 until IDLE is re-entered.
- FSM states: IDLE -> CMD (8 bits, 0x03) -> ADDR (24 bits, MSB first) -> DATA (32*(len_i+1) bits) -> DESELECT -> IDLE.
- Bit timing: at E1 flash_csn=0, flash_clk=0, flash_mosi=first bit.
  - Global bit k has a low phase of CLK_DIV cycles, then flash_clk=1 for CLK_DIV cycles.
  - flash_mosi changes only while flash_clk=0, coincident with the falling edge.
  - flash_miso is captured at the clk edge that drives flash_clk 1->0.
- flash_mosi is 0 during DATA.
- Word assembly: a byte is shifted MSB first; byte n of the word goes to data_o[8n+7:8n].
  - data_valid_o is asserted for exactly one cycle starting at the edge that captures the word's 32nd bit; data_o is updated at the same edge.
  - data_o holds its value until the next word.
- Latency: first data_valid_o at E(1+128*CLK_DIV); following words every 64*CLK_DIV cycles.
- End of burst: at the capture edge of the last bit, flash_clk=0 and the FSM enters DESELECT. flash_csn goes high at the next edge.
- DESELECT: holds flash_csn=1 for CS_HIGH_CYCLES cycles, then IDLE with cmd_ready_o=1. busy_o=1 throughout.
- Address wrap: the flash wraps internally. The block sends the address unchanged and never splits bursts.
- abort_i in any state other than IDLE:
  - next edge: flash_csn=1, flash_clk=0, state DESELECT.
  - No data_valid_o after the abort edge; a partial word is discarded.
  - abort_i in IDLE is ignored.
- abort_i coinciding with a word-completion edge: that word is still delivered, then the abort is taken.
- cmd_valid_i while busy is ignored; there is no queueing.
- rst_i mid-transfer: all outputs return to reset values at the next edge (csn high immediately), and the FSM returns to IDLE without a deselect hold.

Test Plan:
- CLK_DIV=1, addr 0x000100, len_i=0, flash preloaded bytes 0x11,0x22,0x33,0x44 -> MOSI stream 0x03,0x00,0x01,0x00; one data_valid_o at E129 with data_o=0x44332211; csn high at E130; cmd_ready_o=1 at E132.
- CLK_DIV=2, len_i=3, addr 0x000000 -> 4 pulses at E257, E385, E513, E641; words match flash contents in order.
- len_i=255 at addr 0xFFFFFC -> 256 pulses, first word from 0xFFFFFC, second from 0x000000 (flash wrap); csn low continuously.
- abort_i pulsed during ADDR and again mid-word 2 of a 4-word burst -> no pulse after the abort edge; csn high next edge; cmd_ready_o returns after CS_HIGH_CYCLES.
- rst_i asserted mid-DATA -> next edge csn=1, clk=0, data_valid_o=0, cmd_ready_o=1; a new request then completes correctly.
- cmd_valid_i held high across a burst -> exactly one transaction per ready window; the second starts no earlier than CS_HIGH_CYCLES after csn rises.

Source files
------------

// File: rtl/flash_master.sv
// SPI mode-0 flash read master: sends READ (0x03) plus a 24-bit address, then
// streams little-endian 32-bit words back with one data_valid_o pulse per word.
module flash_master #(
    parameter int unsigned CLK_DIV        = 1,
    parameter int unsigned CS_HIGH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [23:0] addr_i,
    input  logic [7:0]  len_i,
    input  logic        abort_i,
    output logic [31:0] data_o,
    output logic        data_valid_o,
    output logic        busy_o,
    output logic        flash_csn,
    output logic        flash_clk,
    output logic        flash_mosi,
    input  logic        flash_miso,
    output logic        flash_wpn,
    output logic        flash_holdn
);
    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HOLD_W = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HIGH_CYCLES - 1);
    localparam logic [7:0]        READ_CMD  = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_DESELECT
    } state_e;

    state_e            state_q, state_d;
    logic              csn_q, csn_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic [31:0]       tx_q, tx_d;
    logic [31:0]       rx_q, rx_d;
    logic [31:0]       data_q, data_d;
    logic              valid_q, valid_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [4:0]        bit_q, bit_d;
    logic [7:0]        word_q, word_d;
    logic [7:0]        len_q, len_d;

    logic [31:0]       rx_shift;

    assign rx_shift = {rx_q[30:0], flash_miso};

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no path
        // through this block leaves a variable unassigned and infers a latch.
        state_d = state_q;
        csn_d   = csn_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        data_d  = data_q;
        valid_d = 1'b0;
        div_d   = div_q;
        hold_d  = hold_q;
        bit_d   = bit_q;
        word_d  = word_q;
        len_d   = len_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    tx_d    = {READ_CMD, addr_i};
                    len_d   = len_i;
                    state_d = ST_CMD;
                end
            end

            ST_CMD, ST_ADDR, ST_DATA: begin
                if (csn_q) begin
                    // Setup cycle after the handshake: select the flash, present the first bit.
                    csn_d  = 1'b0;
                    sck_d  = 1'b0;
                    mosi_d = tx_q[31];
                    tx_d   = {tx_q[30:0], 1'b0};
                    div_d  = '0;
                    bit_d  = '0;
                    word_d = '0;
                end else if (div_q != DIV_LAST) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (sck_q) begin
                        // Falling SCK: the bit is done; sample MISO and advance MOSI.
                        bit_d  = bit_q + 5'd1;
                        mosi_d = tx_q[31];
                        tx_d   = {tx_q[30:0], 1'b0};
                        if (state_q == ST_CMD && bit_q == 5'd7) begin
                            state_d = ST_ADDR;
                            bit_d   = '0;
                        end else if (state_q == ST_ADDR && bit_q == 5'd23) begin
                            state_d = ST_DATA;
                            bit_d   = '0;
                            mosi_d  = 1'b0;
                        end else if (state_q == ST_DATA) begin
                            mosi_d = 1'b0;
                            rx_d   = rx_shift;
                            if (bit_q == 5'd31) begin
                                // First byte on the wire lands in the low byte.
                                data_d  = {rx_shift[7:0], rx_shift[15:8],
                                           rx_shift[23:16], rx_shift[31:24]};
                                valid_d = 1'b1;
                                if (word_q == len_q) begin
                                    state_d = ST_DESELECT;
                                end else begin
                                    word_d = word_q + 8'd1;
                                end
                            end
                        end
                    end
                end

                // A word completing on this same edge has already been delivered above.
                if (abort_i) begin
                    state_d = ST_DESELECT;
                    csn_d   = 1'b1;
                    sck_d   = 1'b0;
                    mosi_d  = 1'b0;
                    hold_d  = '0;
                end
            end

            ST_DESELECT: begin
                if (!csn_q) begin
                    csn_d  = 1'b1;
                    sck_d  = 1'b0;
                    mosi_d = 1'b0;
                    hold_d = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the datapath registers are reset too, so a reset mid-burst
            // leaves no stale word on data_o and no half-shifted command.
            state_q <= ST_IDLE;
            csn_q   <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            div_q   <= '0;
            hold_q  <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            csn_q   <= csn_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            div_q   <= div_d;
            hold_q  <= hold_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            len_q   <= len_d;
        end
    end

    assign cmd_ready_o  = (state_q == ST_IDLE);
    assign busy_o       = (state_q != ST_IDLE);
    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign flash_csn    = csn_q;
    assign flash_clk    = sck_q;
    assign flash_mosi   = mosi_q;
    assign flash_wpn    = 1'b1;
    assign flash_holdn  = 1'b1;

endmodule

// File: tb/tb_flash_master.sv
// Directed bench for flash_master: two instances (CLK_DIV=1/CS=2 and CLK_DIV=2/CS=3)
// share one behavioural SPI flash; sel picks which instance is being exercised.
`timescale 1ns/1ps
module tb_flash_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cmd_valid, abort, sel, miso;
    logic [23:0] addr;
    logic [7:0]  len;

    logic        a_ready, a_valid, a_busy, a_csn, a_sck, a_mosi, a_wpn, a_holdn;
    logic        b_ready, b_valid, b_busy, b_csn, b_sck, b_mosi, b_wpn, b_holdn;
    logic [31:0] a_data, b_data;

    flash_master #(.CLK_DIV(1), .CS_HIGH_CYCLES(2)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid & ~sel), .cmd_ready_o(a_ready),
        .addr_i(addr), .len_i(len), .abort_i(abort & ~sel), .data_o(a_data),
        .data_valid_o(a_valid), .busy_o(a_busy), .flash_csn(a_csn), .flash_clk(a_sck),
        .flash_mosi(a_mosi), .flash_miso(miso), .flash_wpn(a_wpn), .flash_holdn(a_holdn)
    );

    flash_master #(.CLK_DIV(2), .CS_HIGH_CYCLES(3)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid & sel), .cmd_ready_o(b_ready),
        .addr_i(addr), .len_i(len), .abort_i(abort & sel), .data_o(b_data),
        .data_valid_o(b_valid), .busy_o(b_busy), .flash_csn(b_csn), .flash_clk(b_sck),
        .flash_mosi(b_mosi), .flash_miso(miso), .flash_wpn(b_wpn), .flash_holdn(b_holdn)
    );

    logic        ready, dvalid, busy, csn, sck, mosi, wpn, holdn;
    logic [31:0] data;
    assign ready  = sel ? b_ready : a_ready;
    assign dvalid = sel ? b_valid : a_valid;
    assign busy   = sel ? b_busy  : a_busy;
    assign csn    = sel ? b_csn   : a_csn;
    assign sck    = sel ? b_sck   : a_sck;
    assign mosi   = sel ? b_mosi  : a_mosi;
    assign wpn    = sel ? b_wpn   : a_wpn;
    assign holdn  = sel ? b_holdn : a_holdn;
    assign data   = sel ? b_data  : a_data;

    // Behavioural flash: explicit bytes where preloaded, an address pattern elsewhere.
    logic [7:0] mem [logic [23:0]];

    function automatic logic [7:0] byte_at(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] word_at(input logic [23:0] a);
        return {byte_at(a + 24'd3), byte_at(a + 24'd2), byte_at(a + 24'd1), byte_at(a)};
    endfunction

    int          sl_bits = 0, sl_dbit = 0;
    logic [31:0] sl_shift = '0;
    logic [7:0]  sl_cmd = '0, sl_byte;
    logic [23:0] sl_addr = '0, sl_baddr;

    always @(negedge csn) begin
        sl_bits = 0; sl_dbit = 0; sl_shift = '0; miso = 1'b0;
    end

    always @(posedge sck) begin
        if (!csn && sl_bits < 32) begin
            sl_shift = {sl_shift[30:0], mosi};
            sl_bits++;
            if (sl_bits == 32) begin
                sl_cmd  = sl_shift[31:24];
                sl_addr = sl_shift[23:0];
            end
        end
    end

    always @(negedge sck) begin
        if (!csn && sl_bits >= 32) begin
            sl_baddr = sl_addr + 24'(sl_dbit / 8);
            sl_byte  = byte_at(sl_baddr);
            miso     = sl_byte[7 - (sl_dbit % 8)];
            sl_dbit++;
        end
    end

    // Monitor: histories are indexed by the number of the clk edge just passed.
    typedef struct { int t; logic [31:0] d; } pulse_t;
    pulse_t pq[$];
    int     hs_q[$];
    bit     csn_h[int], sck_h[int], rdy_h[int], busy_h[int];
    int     cyc = 0, mosi_viol = 0;
    logic   prev_rdy = 1'b0, prev_mosi = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (cmd_valid && prev_rdy) hs_q.push_back(cyc);
        prev_rdy = ready;
        csn_h[cyc] = csn; sck_h[cyc] = sck; rdy_h[cyc] = ready; busy_h[cyc] = busy;
        if (sck === 1'b1 && mosi !== prev_mosi) mosi_viol++;
        prev_mosi = mosi;
        if (dvalid === 1'b1) pq.push_back('{t: cyc, d: data});
    end

    int vectors = 0, miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int p_t(input int i);
        return (i < pq.size()) ? pq[i].t : -1;
    endfunction

    function automatic logic [31:0] p_d(input int i);
        return (i < pq.size()) ? pq[i].d : 32'hDEAD_0BAD;
    endfunction

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic run_to(input int t);
        for (int i = 0; i < 100000 && cyc < t; i++) step(1);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        for (int i = 0; i < bound && !(ready && !busy); i++) step(1);
        check(tag, 32'(ready & ~busy), 32'h1);
    endtask

    task automatic issue(input logic [23:0] a, input logic [7:0] l, output int e0);
        int n0;
        n0 = hs_q.size();
        cmd_valid = 1'b1; addr = a; len = l;
        for (int i = 0; i < 20 && hs_q.size() == n0; i++) step(1);
        cmd_valid = 1'b0;
        check("issue_accept", 32'(hs_q.size() - n0), 32'h1);
        e0 = (hs_q.size() > n0) ? hs_q[$] : cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, ea, last, n0, err;
        rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0; sel = 1'b0; addr = '0; len = '0;
        mem[24'h000100] = 8'h11; mem[24'h000101] = 8'h22;
        mem[24'h000102] = 8'h33; mem[24'h000103] = 8'h44;
        mem[24'hFFFFFC] = 8'hDE; mem[24'hFFFFFD] = 8'hAD;
        mem[24'hFFFFFE] = 8'hBE; mem[24'hFFFFFF] = 8'hEF;
        mem[24'h000000] = 8'h01; mem[24'h000001] = 8'h02;
        mem[24'h000002] = 8'h03; mem[24'h000003] = 8'h04;
        step(3);

        // Reset state: {ready,busy,valid,csn,sck,mosi,wpn,holdn} and data.
        check("reset_a_ctl", 32'({ready, busy, dvalid, csn, sck, mosi, wpn, holdn}), 32'h93);
        check("reset_a_data", data, 32'h0);
        sel = 1'b1; step(1);
        check("reset_b_ctl", 32'({ready, busy, dvalid, csn, sck, mosi, wpn, holdn}), 32'h93);
        check("reset_b_data", data, 32'h0);
        rst = 1'b0; sel = 1'b0; step(2);

        // Single word, CLK_DIV=1.
        pq.delete();
        issue(24'h000100, 8'd0, e0);
        wait_idle("t1_idle", 400);
        check("t1_pulses", 32'(pq.size()), 32'd1);
        check("t1_time", 32'(p_t(0) - e0), 32'd129);
        check("t1_data", p_d(0), 32'h4433_2211);
        check("t1_csn", 32'({csn_h[e0], csn_h[e0+1], csn_h[e0+129], csn_h[e0+130]}), 32'b1001);
        check("t1_ready", 32'({rdy_h[e0], busy_h[e0+131], rdy_h[e0+131], rdy_h[e0+132]}), 32'b0101);
        check("t1_cmd", 32'(sl_cmd), 32'h03);
        check("t1_addr", 32'(sl_addr), 32'h000100);
        step(5);
        check("t1_hold", data, 32'h4433_2211);

        // Four words, CLK_DIV=2, CS_HIGH_CYCLES=3.
        sel = 1'b1; step(2);
        pq.delete();
        issue(24'h000000, 8'd3, e0);
        wait_idle("t2_idle", 1000);
        check("t2_pulses", 32'(pq.size()), 32'd4);
        check("t2_word0", p_d(0), 32'h0403_0201);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_time%0d", k), 32'(p_t(k) - e0), 32'(257 + 128 * k));
            check($sformatf("t2_data%0d", k), p_d(k), word_at(24'(4 * k)));
        end
        last = p_t(3);
        check("t2_deselect", 32'({csn_h[last], csn_h[last+1], rdy_h[last+3], rdy_h[last+4]}), 32'b0101);

        // 256-word burst across the top of the address space, CLK_DIV=1.
        sel = 1'b0; step(2);
        pq.delete();
        issue(24'hFFFFFC, 8'd255, e0);
        wait_idle("t3_idle", 20000);
        check("t3_pulses", 32'(pq.size()), 32'd256);
        check("t3_word0", p_d(0), 32'hEFBE_ADDE);
        check("t3_word1", p_d(1), 32'h0403_0201);
        check("t3_word255", p_d(255), word_at(24'h0003F8));
        check("t3_addr", 32'(sl_addr), 32'hFFFFFC);
        err = 0;
        for (int k = 0; k < 256; k++) if (p_t(k) != e0 + 129 + 64 * k) err++;
        check("t3_spacing", 32'(err), 32'd0);
        err = 0;
        for (int t = e0 + 1; t <= e0 + 129 + 64 * 255; t++) if (csn_h[t]) err++;
        check("t3_csn_low", 32'(err), 32'd0);

        // Abort during ADDR.
        pq.delete();
        issue(24'h000010, 8'd3, e0);
        run_to(e0 + 19);
        abort = 1'b1; step(1); ea = cyc; abort = 1'b0;
        wait_idle("t4a_idle", 100);
        step(10);
        check("t4a_pulses", 32'(pq.size()), 32'd0);
        check("t4a_pins", 32'({csn_h[ea-1], csn_h[ea], sck_h[ea], rdy_h[ea+1], rdy_h[ea+2]}), 32'b01001);

        // Abort in the middle of the second word.
        pq.delete();
        issue(24'h000020, 8'd3, e0);
        run_to(e0 + 159);
        abort = 1'b1; step(1); ea = cyc; abort = 1'b0;
        wait_idle("t4b_idle", 100);
        step(100);
        check("t4b_pulses", 32'(pq.size()), 32'd1);
        check("t4b_time", 32'(p_t(0) - e0), 32'd129);
        check("t4b_data", p_d(0), word_at(24'h000020));
        check("t4b_pins", 32'({csn_h[ea-1], csn_h[ea], sck_h[ea], rdy_h[ea+1], rdy_h[ea+2]}), 32'b01001);

        // Abort on the edge that completes the first word: the word is still delivered.
        pq.delete();
        issue(24'h000030, 8'd3, e0);
        run_to(e0 + 128);
        abort = 1'b1; step(1); abort = 1'b0;
        wait_idle("t4c_idle", 100);
        step(100);
        check("t4c_pulses", 32'(pq.size()), 32'd1);
        check("t4c_time", 32'(p_t(0) - e0), 32'd129);
        check("t4c_data", p_d(0), word_at(24'h000030));
        check("t4c_csn", 32'(csn_h[e0+129]), 32'h1);

        // Abort while idle has no effect.
        abort = 1'b1; step(2); abort = 1'b0;
        check("t4d_idle_abort", 32'({ready, busy, csn}), 32'b101);

        // Reset in the middle of DATA, then a clean transaction.
        sel = 1'b1; step(2);
        pq.delete();
        issue(24'h000040, 8'd3, e0);
        run_to(e0 + 299);
        rst = 1'b1; step(1);
        check("t5_pulses_before", 32'(pq.size()), 32'd1);
        check("t5_rst_ctl", 32'({csn, sck, dvalid, ready, busy}), 32'b10010);
        check("t5_rst_data", data, 32'h0);
        rst = 1'b0; step(1);
        pq.delete();
        issue(24'h000080, 8'd0, e0);
        wait_idle("t5_idle", 600);
        check("t5_pulses_after", 32'(pq.size()), 32'd1);
        check("t5_time", 32'(p_t(0) - e0), 32'd257);
        check("t5_data", p_d(0), word_at(24'h000080));

        // cmd_valid held high: one transaction per ready window.
        sel = 1'b0; step(2);
        pq.delete();
        n0 = hs_q.size();
        cmd_valid = 1'b1; addr = 24'h000100; len = 8'd0;
        for (int i = 0; i < 400 && hs_q.size() < n0 + 2; i++) step(1);
        cmd_valid = 1'b0;
        wait_idle("t6_idle", 400);
        check("t6_handshakes", 32'(hs_q.size() - n0), 32'd2);
        if (hs_q.size() >= n0 + 2) begin
            check("t6_gap", 32'(hs_q[n0+1] - hs_q[n0]), 32'd133);
            check("t6_csn_at_e0", 32'(csn_h[hs_q[n0+1]]), 32'h1);
        end
        check("t6_pulses", 32'(pq.size()), 32'd2);
        check("t6_data0", p_d(0), 32'h4433_2211);
        check("t6_data1", p_d(1), 32'h4433_2211);

        check("mosi_stable", 32'(mosi_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
